// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multicycle MIPS sequencer: FSM states, instruction classes
// and the encodings of the pc_src, wb_sel and err_code outputs.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC   = 4'd2,
    MEM_RD = 4'd3,
    MEM_WR = 4'd4,
    WB     = 4'd5,
    BRANCH = 4'd6,
    JUMP   = 4'd7,
    TRAP   = 4'd8
  } state_t;

  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_RALU,
    CLS_JR,
    CLS_JALR,
    CLS_LOAD,
    CLS_STORE,
    CLS_IALU,
    CLS_BR,
    CLS_J,
    CLS_JAL,
    CLS_ILLEGAL
  } cls_t;

  localparam logic [1:0] PC_SRC_PC4 = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;
  localparam logic [1:0] PC_SRC_RS  = 2'd3;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MDR = 2'd1;
  localparam logic [1:0] WB_SEL_PC  = 2'd2;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/mc_classify.sv
// Combinational instruction classifier: maps opcode/funct (rt reserved) onto the
// instruction class the sequencer steps through.
module mc_classify
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  output cls_t       cls
);

  // rt is part of the classifier contract but no current class depends on it
  logic unused_rt;
  assign unused_rt = ^rt;

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h00:                      cls = CLS_NOP;
          6'h08:                      cls = CLS_JR;
          6'h09:                      cls = CLS_JALR;
          6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B:               cls = CLS_RALU;
          default:                    cls = CLS_ILLEGAL;
        endcase
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: cls = CLS_LOAD;
      6'h28, 6'h29, 6'h2B:               cls = CLS_STORE;
      6'h08, 6'h09, 6'h0C, 6'h0D,
      6'h0E, 6'h0F:                      cls = CLS_IALU;
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: cls = CLS_BR;
      6'h02:                             cls = CLS_J;
      6'h03:                             cls = CLS_JAL;
      default:                           cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control sequencer (fetch/decode/exec/mem/wb) with req/ack memory
// handshake and timeout trap. Define MC_CTRL_PERF_EN to build the perf counters.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  rt,
  input  logic        br_taken,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        mdr_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  wb_sel,
  output logic        instr_done,
  output logic        trap,
  output logic [1:0]  err_code,
  output logic [3:0]  state,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt,
  output logic [31:0] stall_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t             state_reg, state_next;
  cls_t               cls_dec, cls_reg;
  logic [1:0]         err_reg, err_next;
  logic [WAIT_W-1:0]  wait_reg;
  logic               timeout;

  mc_classify u_classify (
    .opcode (opcode),
    .funct  (funct),
    .rt     (rt),
    .cls    (cls_dec)
  );

  // Last waiting cycle: an ack here still wins over the trap
  assign timeout = (wait_reg == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    mdr_we     = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    pc_src     = PC_SRC_PC4;
    wb_sel     = WB_SEL_ALU;
    instr_done = 1'b0;
    trap       = 1'b0;
    case (state_reg)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = DECODE;
        end else if (timeout) begin
          state_next = TRAP;
          err_next   = ERR_TIMEOUT;
        end
      end
      DECODE: begin
        case (cls_dec)
          CLS_NOP: begin
            instr_done = 1'b1;
            state_next = FETCH;
          end
          CLS_BR:                           state_next = BRANCH;
          CLS_J, CLS_JAL, CLS_JR, CLS_JALR: state_next = JUMP;
          CLS_ILLEGAL: begin
            state_next = TRAP;
            err_next   = ERR_ILLEGAL;
          end
          default:                          state_next = EXEC;
        endcase
      end
      EXEC: begin
        case (cls_reg)
          CLS_LOAD:  state_next = MEM_RD;
          CLS_STORE: state_next = MEM_WR;
          default:   state_next = WB;
        endcase
      end
      MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (mem_ack) begin
          mdr_we     = 1'b1;
          state_next = WB;
        end else if (timeout) begin
          state_next = TRAP;
          err_next   = ERR_TIMEOUT;
        end
      end
      MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ack) begin
          instr_done = 1'b1;
          state_next = FETCH;
        end else if (timeout) begin
          state_next = TRAP;
          err_next   = ERR_TIMEOUT;
        end
      end
      WB: begin
        reg_we     = 1'b1;
        wb_sel     = (cls_reg == CLS_LOAD) ? WB_SEL_MDR : WB_SEL_ALU;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        pc_src     = PC_SRC_BR;
        pc_we      = br_taken;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      JUMP: begin
        pc_we  = 1'b1;
        pc_src = (cls_reg == CLS_J || cls_reg == CLS_JAL) ? PC_SRC_JMP : PC_SRC_RS;
        if (cls_reg == CLS_JAL || cls_reg == CLS_JALR) begin
          reg_we = 1'b1;
          wb_sel = WB_SEL_PC;
        end
        instr_done = 1'b1;
        state_next = FETCH;
      end
      TRAP:    trap = 1'b1;
      default: state_next = FETCH;
    endcase
    state    = state_reg;
    err_code = err_reg;
    // Nothing may issue while reset is held, even mid-instruction
    if (rst) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_sel   = 1'b0;
      ir_we      = 1'b0;
      mdr_we     = 1'b0;
      pc_we      = 1'b0;
      reg_we     = 1'b0;
      pc_src     = PC_SRC_PC4;
      wb_sel     = WB_SEL_ALU;
      instr_done = 1'b0;
      trap       = 1'b0;
      state      = FETCH;
      err_code   = ERR_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FETCH;
      cls_reg   <= CLS_NOP;
      err_reg   <= ERR_NONE;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
      if (state_reg == DECODE)
        cls_reg <= cls_dec;
      if (state_next != state_reg)
        wait_reg <= '0;
      else if (mem_req && !mem_ack)
        wait_reg <= wait_reg + WAIT_W'(1);
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_reg, instr_reg, stall_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_reg <= '0;
      instr_reg <= '0;
      stall_reg <= '0;
    end else begin
      if (state_reg != TRAP)
        cycle_reg <= cycle_reg + 32'd1;
      if (instr_done)
        instr_reg <= instr_reg + 32'd1;
      if (mem_req && !mem_ack)
        stall_reg <= stall_reg + 32'd1;
    end
  end

  assign cycle_cnt = rst ? 32'd0 : cycle_reg;
  assign instr_cnt = rst ? 32'd0 : instr_reg;
  assign stall_cnt = rst ? 32'd0 : stall_reg;
`else
  assign cycle_cnt = 32'd0;
  assign instr_cnt = 32'd0;
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (MEM_TIMEOUT=4); counter
// expectations follow MC_CTRL_PERF_EN.
module tb_multicycle_ctrl;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic [4:0]  rt = '0;
  logic        br_taken = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, reg_we;
  logic [1:0]  pc_src, wb_sel, err_code;
  logic        instr_done, trap;
  logic [3:0]  state;
  logic [31:0] cycle_cnt, instr_cnt, stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [3:0] tr_state  [1:16];
  logic       tr_reg_we [1:16];
  logic       tr_pc_we  [1:16];
  logic       tr_ir_we  [1:16];
  logic       tr_mdr_we [1:16];
  logic       tr_mem_we [1:16];
  logic [1:0] tr_pc_src [1:16];
  logic [1:0] tr_wb_sel [1:16];

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .rt         (rt),
    .br_taken   (br_taken),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .addr_sel   (addr_sel),
    .ir_we      (ir_we),
    .mdr_we     (mdr_we),
    .pc_we      (pc_we),
    .reg_we     (reg_we),
    .pc_src     (pc_src),
    .wb_sel     (wb_sel),
    .instr_done (instr_done),
    .trap       (trap),
    .err_code   (err_code),
    .state      (state),
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt),
    .stall_cnt  (stall_cnt)
  );

  // One-cycle reset pulse; returns just after the negedge where rst falls
  task automatic apply_reset;
    rst = 1'b1;
    mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Plays one instruction from FETCH, acting as the memory responder; records a
  // per-cycle trace and the cycle (1-based from fetch) on which instr_done pulsed
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fetch_wait, input int mem_wait,
                           input logic taken, output int done_cyc);
    int n;
    logic [3:0] prev;
    n = 0;
    prev = 4'hF;
    done_cyc = 0;
    opcode = op;
    funct = fn;
    br_taken = taken;
    for (int c = 1; c <= 16; c++) begin
      if (state == prev) n++;
      else n = 0;
      prev = state;
      mem_ack = ((state == FETCH) && n == fetch_wait) ||
                ((state == MEM_RD || state == MEM_WR) && n == mem_wait);
      #1;
      tr_state[c]  = state;
      tr_reg_we[c] = reg_we;
      tr_pc_we[c]  = pc_we;
      tr_ir_we[c]  = ir_we;
      tr_mdr_we[c] = mdr_we;
      tr_mem_we[c] = mem_we;
      tr_pc_src[c] = pc_src;
      tr_wb_sel[c] = wb_sel;
      if (instr_done && done_cyc == 0) done_cyc = c;
      @(negedge clk);
      if (done_cyc != 0) break;
    end
    mem_ack = 1'b0;
    $display("instr op=%h funct=%h fetch_wait=%0d mem_wait=%0d retired_on_cycle=%0d",
             op, fn, fetch_wait, mem_wait, done_cyc);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    opcode = 6'h23;
    mem_ack = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, reg_we, instr_done, trap} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000000",
               {mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, reg_we, instr_done, trap});
    end
    checks++;
    if (state !== 4'd0 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got state=%0d err=%0d expected 0 0", state, err_code);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got state=%0d mem_req=%b expected 0 1", state, mem_req);
    end
    checks++;
    if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: got %0d %0d %0d expected 0 0 0", cycle_cnt, instr_cnt, stall_cnt);
    end
    // Abort an add while in EXEC
    opcode = 6'h00;
    funct = 6'h20;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mem_ack = 1'b1;
    #1;
    checks++;
    if ({mem_req, ir_we, pc_we, reg_we, mdr_we, instr_done} !== 6'd0 || state !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_instr: got en=%b state=%0d expected 000000 0",
               {mem_req, ir_we, pc_we, reg_we, mdr_we, instr_done}, state);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_release: got state=%0d mem_req=%b expected 0 1", state, mem_req);
    end
    @(negedge clk);
  endtask

  task automatic test_alu;
    int d;
    apply_reset();
    run_instr(6'h00, 6'h20, 0, 0, 1'b0, d);
    checks++;
    if (d !== 4) begin
      errors++;
      $display("FAIL add_latency: got %0d expected 4", d);
    end
    checks++;
    if (tr_ir_we[1] !== 1'b1 || tr_pc_we[1] !== 1'b1 || tr_pc_src[1] !== 2'd0) begin
      errors++;
      $display("FAIL add_fetch: got ir_we=%b pc_we=%b pc_src=%0d expected 1 1 0",
               tr_ir_we[1], tr_pc_we[1], tr_pc_src[1]);
    end
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (tr_reg_we[c] !== (c == 4)) begin
        errors++;
        $display("FAIL add_reg_we cycle %0d: got %b expected %b", c, tr_reg_we[c], c == 4);
      end
    end
    checks++;
    if (tr_state[4] !== 4'd5 || tr_wb_sel[4] !== 2'd0) begin
      errors++;
      $display("FAIL add_wb: got state=%0d wb_sel=%0d expected 5 0", tr_state[4], tr_wb_sel[4]);
    end
    run_instr(6'h0D, 6'h00, 0, 0, 1'b0, d);
    checks++;
    if (d !== 4) begin
      errors++;
      $display("FAIL ori_latency: got %0d expected 4", d);
    end
    run_instr(6'h2B, 6'h00, 0, 0, 1'b0, d);
    checks++;
    if (d !== 4 || tr_state[4] !== 4'd4 || tr_mem_we[4] !== 1'b1) begin
      errors++;
      $display("FAIL sw: got done=%0d state=%0d mem_we=%b expected 4 4 1", d, tr_state[4], tr_mem_we[4]);
    end
  endtask

  task automatic test_load;
    int d;
    logic [31:0] s0;
    s0 = stall_cnt;
    run_instr(6'h23, 6'h00, 0, 3, 1'b0, d);
    checks++;
    if (d !== 8) begin
      errors++;
      $display("FAIL lw_latency: got %0d expected 8", d);
    end
    checks++;
    if (tr_mdr_we[6] !== 1'b0 || tr_mdr_we[7] !== 1'b1) begin
      errors++;
      $display("FAIL lw_mdr_we: got c6=%b c7=%b expected 0 1", tr_mdr_we[6], tr_mdr_we[7]);
    end
    checks++;
    if (tr_state[8] !== 4'd5 || tr_wb_sel[8] !== 2'd1 || tr_reg_we[8] !== 1'b1) begin
      errors++;
      $display("FAIL lw_wb: got state=%0d wb_sel=%0d reg_we=%b expected 5 1 1",
               tr_state[8], tr_wb_sel[8], tr_reg_we[8]);
    end
`ifdef MC_CTRL_PERF_EN
    checks++;
    if (stall_cnt - s0 !== 32'd3) begin
      errors++;
      $display("FAIL lw_stall: got %0d expected 3", stall_cnt - s0);
    end
`else
    checks++;
    if (stall_cnt !== 32'd0 || s0 !== 32'd0) begin
      errors++;
      $display("FAIL lw_stall_off: got %0d expected 0", stall_cnt);
    end
`endif
  endtask

  task automatic test_branch;
    int d;
    run_instr(6'h04, 6'h00, 0, 0, 1'b0, d);
    checks++;
    if (d !== 3 || tr_state[3] !== 4'd6 || tr_pc_we[3] !== 1'b0) begin
      errors++;
      $display("FAIL beq_not_taken: got done=%0d state=%0d pc_we=%b expected 3 6 0", d, tr_state[3], tr_pc_we[3]);
    end
    run_instr(6'h04, 6'h00, 0, 0, 1'b1, d);
    checks++;
    if (d !== 3 || tr_pc_we[3] !== 1'b1 || tr_pc_src[3] !== 2'd1) begin
      errors++;
      $display("FAIL beq_taken: got done=%0d pc_we=%b pc_src=%0d expected 3 1 1", d, tr_pc_we[3], tr_pc_src[3]);
    end
    br_taken = 1'b0;
  endtask

  task automatic test_jump;
    int d;
    run_instr(6'h03, 6'h00, 0, 0, 1'b0, d);
    checks++;
    if (d !== 3 || tr_state[3] !== 4'd7 || tr_pc_src[3] !== 2'd2 || tr_reg_we[3] !== 1'b1 || tr_wb_sel[3] !== 2'd2) begin
      errors++;
      $display("FAIL jal: got done=%0d state=%0d pc_src=%0d reg_we=%b wb_sel=%0d expected 3 7 2 1 2",
               d, tr_state[3], tr_pc_src[3], tr_reg_we[3], tr_wb_sel[3]);
    end
    run_instr(6'h00, 6'h08, 0, 0, 1'b0, d);
    checks++;
    if (d !== 3 || tr_pc_src[3] !== 2'd3 || tr_reg_we[3] !== 1'b0 || tr_pc_we[3] !== 1'b1) begin
      errors++;
      $display("FAIL jr: got done=%0d pc_src=%0d reg_we=%b pc_we=%b expected 3 3 0 1",
               d, tr_pc_src[3], tr_reg_we[3], tr_pc_we[3]);
    end
    run_instr(6'h00, 6'h09, 0, 0, 1'b0, d);
    checks++;
    if (d !== 3 || tr_pc_src[3] !== 2'd3 || tr_reg_we[3] !== 1'b1 || tr_wb_sel[3] !== 2'd2) begin
      errors++;
      $display("FAIL jalr: got done=%0d pc_src=%0d reg_we=%b wb_sel=%0d expected 3 3 1 2",
               d, tr_pc_src[3], tr_reg_we[3], tr_wb_sel[3]);
    end
  endtask

  task automatic test_illegal;
    int d;
    int bad;
    run_instr(6'h3F, 6'h00, 0, 0, 1'b0, d);
    checks++;
    if (d !== 0 || tr_state[2] !== 4'd1 || tr_state[3] !== 4'd8) begin
      errors++;
      $display("FAIL illegal_trap: got done=%0d s2=%0d s3=%0d expected 0 1 8", d, tr_state[2], tr_state[3]);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      mem_ack = c[0];
      #1;
      if (mem_req !== 1'b0 || trap !== 1'b1 || err_code !== 2'd1) bad++;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL illegal_hold: got %0d bad cycles expected 0", bad);
    end
    apply_reset();
    #1;
    checks++;
    if (state !== 4'd0 || mem_req !== 1'b1 || trap !== 1'b0 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL illegal_recover: got state=%0d mem_req=%b trap=%b err=%0d expected 0 1 0 0",
               state, mem_req, trap, err_code);
    end
    @(negedge clk);
    apply_reset();
  endtask

  task automatic test_timeout;
    int d;
    run_instr(6'h00, 6'h20, 99, 0, 1'b0, d);
    checks++;
    if (tr_state[4] !== 4'd0 || tr_state[5] !== 4'd8 || err_code !== 2'd2 || trap !== 1'b1) begin
      errors++;
      $display("FAIL fetch_timeout: got s4=%0d s5=%0d err=%0d trap=%b expected 0 8 2 1",
               tr_state[4], tr_state[5], err_code, trap);
    end
    apply_reset();
    run_instr(6'h00, 6'h00, 3, 0, 1'b0, d);
    checks++;
    if (d !== 5 || tr_state[5] !== 4'd1 || trap !== 1'b0 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL ack_at_timeout: got done=%0d s5=%0d trap=%b err=%0d expected 5 1 0 0",
               d, tr_state[5], trap, err_code);
    end
    run_instr(6'h2B, 6'h00, 0, 99, 1'b0, d);
    checks++;
    if (tr_state[7] !== 4'd4 || tr_state[8] !== 4'd8 || err_code !== 2'd2) begin
      errors++;
      $display("FAIL memwr_timeout: got s7=%0d s8=%0d err=%0d expected 4 8 2", tr_state[7], tr_state[8], err_code);
    end
    apply_reset();
  endtask

  task automatic test_back_to_back;
    int d1, d2, d3;
    apply_reset();
    run_instr(6'h00, 6'h00, 0, 0, 1'b0, d1);
    run_instr(6'h00, 6'h2A, 0, 0, 1'b0, d2);
    run_instr(6'h20, 6'h00, 0, 0, 1'b0, d3);
    checks++;
    if (d1 !== 2 || d2 !== 4 || d3 !== 5) begin
      errors++;
      $display("FAIL b2b_latency: got %0d %0d %0d expected 2 4 5", d1, d2, d3);
    end
`ifdef MC_CTRL_PERF_EN
    checks++;
    if (cycle_cnt !== 32'd11 || instr_cnt !== 32'd3 || stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL b2b_counters: got %0d %0d %0d expected 11 3 0", cycle_cnt, instr_cnt, stall_cnt);
    end
`else
    checks++;
    if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL b2b_counters_off: got %0d %0d %0d expected 0 0 0", cycle_cnt, instr_cnt, stall_cnt);
    end
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_alu();
    test_load();
    test_branch();
    test_jump();
    test_illegal();
    test_timeout();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
